// File: rtl/fetch_cycle_if.sv
// Instruction-memory port of the fetch stage: one request at a time,
// accepted on req & ready, answered later by a single rvalid beat.
interface fetch_cycle_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_cycle.sv
// Instruction fetch stage plus IF/ID register: keeps one request in flight,
// buffers one returned word and applies stall, flush and redirect.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_f,
    input  logic               flush_d,
    input  logic               pc_sel,
    input  logic [31:0]        pc_target,
    fetch_cycle_if.master      imem,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc4_d,
    output logic [31:0]        instr,
    output logic               instr_vld_d,
    output logic               fsm_state
);

    typedef enum logic {F_REQ = 1'b0, F_WAIT = 1'b1} state_e;

    state_e      state;
    logic [31:0] pc_f;
    logic [31:0] req_pc;
    logic [31:0] fb_pc;
    logic [31:0] fb_instr;
    logic        fb_valid;
    logic        kill;
    logic        handshake;
    logic        accept;
    logic [31:0] target;

    // Request is valid while the buffer can take the answer; a transfer happens
    // on req & ready, and addr stays at pc_f until that transfer.
    assign imem.req  = rst & (state == F_REQ) & (!fb_valid | !stall_f);
    assign imem.addr = pc_f;
    assign handshake = imem.req & imem.ready;
    assign accept    = (state == F_WAIT) & imem.rvalid & !kill & !pc_sel;
    assign target    = pc_target & ~32'd3;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= F_REQ;
            pc_f        <= RESET_PC;
            req_pc      <= 32'd0;
            fb_pc       <= 32'd0;
            fb_instr    <= 32'd0;
            fb_valid    <= 1'b0;
            kill        <= 1'b0;
            pc_d        <= 32'd0;
            pc4_d       <= 32'd0;
            instr       <= NOP_INSTR;
            instr_vld_d <= 1'b0;
        end else begin
            case (state)
                F_REQ: begin
                    if (handshake) begin
                        req_pc <= pc_f;
                        kill   <= pc_sel;
                        state  <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (imem.rvalid) begin
                        kill  <= 1'b0;
                        state <= F_REQ;
                    end else if (pc_sel) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= F_REQ;
            endcase

            if (pc_sel) pc_f <= target;
            else if (handshake) pc_f <= pc_f + 32'd4;

            // A fill only ever lands in an empty buffer, so set-after-clear is safe.
            if (pc_sel) begin
                fb_valid <= 1'b0;
            end else if (accept) begin
                fb_valid <= 1'b1;
                fb_pc    <= req_pc;
                fb_instr <= imem.rdata;
            end else if (!flush_d && !stall_f) begin
                fb_valid <= 1'b0;
            end

            if (pc_sel || flush_d || (!stall_f && !fb_valid)) begin
                pc_d        <= 32'd0;
                pc4_d       <= 32'd0;
                instr       <= NOP_INSTR;
                instr_vld_d <= 1'b0;
            end else if (!stall_f) begin
                pc_d        <= fb_pc;
                pc4_d       <= fb_pc + 32'd4;
                instr       <= fb_instr;
                instr_vld_d <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_cycle.sv
// Bench for fetch_cycle: directed scenarios then random traffic, all checked
// against a queue-based model of the fetch pipeline and a memory responder.
module tb_fetch_cycle;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        flush_d;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic [31:0] pc_d;
    logic [31:0] pc4_d;
    logic [31:0] instr;
    logic        instr_vld_d;
    logic        fsm_state;

    fetch_cycle_if bus ();

    fetch_cycle #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_f    (stall_f),
        .flush_d    (flush_d),
        .pc_sel     (pc_sel),
        .pc_target  (pc_target),
        .imem       (bus),
        .pc_d       (pc_d),
        .pc4_d      (pc4_d),
        .instr      (instr),
        .instr_vld_d(instr_vld_d),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic        killed;
    } flight_t;

    flight_t     flight_q[$];
    logic [63:0] fb_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pc_d;
    logic [31:0] m_pc4_d;
    logic [31:0] m_instr;
    logic        m_vld;
    int          ready_mode;
    int          rv_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic m_req();
        return (flight_q.size() == 0) && (fb_q.size() == 0 || !stall_f);
    endfunction

    task automatic m_bubble();
        m_pc_d  = 32'd0;
        m_pc4_d = 32'd0;
        m_instr = NOP;
        m_vld   = 1'b0;
    endtask

    task automatic model_reset();
        flight_q.delete();
        fb_q.delete();
        mem_q.delete();
        m_pc = 32'd0;
        m_bubble();
    endtask

    task automatic mem_drive();
        case (ready_mode)
            0:       bus.ready = ($urandom_range(0, 1) == 1);
            1:       bus.ready = 1'b1;
            default: bus.ready = 1'b0;
        endcase
        if (mem_q.size() != 0) begin
            if (rv_mode == 1) bus.rvalid = 1'b1;
            else if (rv_mode == 2) bus.rvalid = 1'b0;
            else bus.rvalid = ($urandom_range(0, 2) != 0);
            bus.rdata = mem_word(mem_q[0]);
        end else begin
            bus.rvalid = (rv_mode == 0) && ($urandom_range(0, 7) == 0);
            bus.rdata  = $urandom;
        end
    endtask

    // One clock of the reference pipeline, evaluated from pre-edge state.
    task automatic model_edge();
        logic        hs;
        logic        resp;
        flight_t     e;
        logic [63:0] f;
        hs   = m_req() && bus.ready;
        resp = (flight_q.size() != 0) && bus.rvalid;
        if (flush_d || pc_sel) begin
            m_bubble();
        end else if (!stall_f) begin
            if (fb_q.size() != 0) begin
                f       = fb_q.pop_front();
                m_pc_d  = f[63:32];
                m_pc4_d = f[63:32] + 32'd4;
                m_instr = f[31:0];
                m_vld   = 1'b1;
            end else begin
                m_bubble();
            end
        end
        if (resp) begin
            e = flight_q.pop_front();
            void'(mem_q.pop_front());
            if (!e.killed && !pc_sel) begin
                chk("fb_free_on_fill", fb_q.size(), 0);
                fb_q.push_back({e.pc, mem_word(e.pc)});
            end
        end
        if (pc_sel) begin
            fb_q.delete();
            foreach (flight_q[i]) flight_q[i].killed = 1'b1;
        end
        if (hs) begin
            e.pc     = m_pc;
            e.killed = pc_sel;
            flight_q.push_back(e);
            mem_q.push_back(m_pc);
        end
        if (pc_sel) m_pc = pc_target & ~32'd3;
        else if (hs) m_pc = m_pc + 32'd4;
    endtask

    task automatic pre();
        mem_drive();
        #1;
        chk("imem_req", bus.req, m_req());
        chk("imem_addr", bus.addr, m_pc);
    endtask

    task automatic post();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pc_d", pc_d, m_pc_d);
        chk("pc4_d", pc4_d, m_pc4_d);
        chk("instr", instr, m_instr);
        chk("instr_vld_d", instr_vld_d, m_vld);
    endtask

    task automatic cyc();
        pre();
        post();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before the run completed");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; stall_f = 1'b0; flush_d = 1'b0; pc_sel = 1'b0; pc_target = 32'd0;
        bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'd0;
        ready_mode = 1; rv_mode = 1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", bus.req, 0);
        chk("rst_pc_d", pc_d, 0);
        chk("rst_instr", instr, NOP);
        chk("rst_vld", instr_vld_d, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single-cycle memory: first two words reach IF/ID two cycles apart.
        repeat (3) cyc();
        chk("t2_pc_d0", pc_d, 32'h0);
        chk("t2_pc4_d0", pc4_d, 32'h4);
        chk("t2_instr0", instr, 32'h0050_0093);
        chk("t2_vld0", instr_vld_d, 1);
        cyc();
        ready_mode = 2;
        cyc();
        chk("t2_pc_d1", pc_d, 32'h4);
        chk("t2_pc4_d1", pc4_d, 32'h8);
        chk("t2_instr1", instr, 32'h00A0_0113);
        chk("t2_vld1", instr_vld_d, 1);

        // Memory back-pressure: address must hold at 0x8.
        repeat (2) cyc();
        ready_mode = 1;
        pre();
        chk("t3_addr_held", bus.addr, 32'h8);
        chk("t3_req_held", bus.req, 1);
        post();
        cyc();

        // Stall with a buffered word: no request, then the word loads.
        stall_f = 1'b1;
        repeat (3) begin
            pre();
            chk("t4_req_low", bus.req, 0);
            post();
        end
        stall_f = 1'b0;
        cyc();
        chk("t4_pc_d", pc_d, 32'h8);
        chk("t4_instr", instr, mem_word(32'h8));

        // Redirect while waiting: late data dropped, fetch resumes at 0x100.
        rv_mode = 2; pc_sel = 1'b1; pc_target = 32'h103;
        cyc();
        pc_sel = 1'b0; rv_mode = 1;
        chk("t5_bubble_instr", instr, NOP);
        chk("t5_bubble_vld", instr_vld_d, 0);
        cyc();
        pre();
        chk("t5_addr", bus.addr, 32'h100);
        post();
        repeat (2) cyc();
        chk("t5_pc_d", pc_d, 32'h100);
        chk("t5_instr", instr, mem_word(32'h100));

        // Redirect coinciding with rvalid, then a lone flush.
        pc_sel = 1'b1; pc_target = 32'h200;
        cyc();
        pc_sel = 1'b0;
        chk("t6_vld_redirect", instr_vld_d, 0);
        pre();
        chk("t6_addr", bus.addr, 32'h200);
        post();
        flush_d = 1'b1;
        cyc();
        flush_d = 1'b0;
        chk("t6_flush_instr", instr, NOP);
        chk("t6_flush_vld", instr_vld_d, 0);
        pre();
        chk("t6_addr_after_flush", bus.addr, 32'h204);
        post();
        chk("t6_pc_d", pc_d, 32'h200);

        // PC wrap at the top of the address space.
        pc_sel = 1'b1; pc_target = 32'hFFFF_FFFF;
        cyc();
        pc_sel = 1'b0;
        repeat (2) cyc();
        pre();
        chk("wrap_addr", bus.addr, 32'h0);
        post();
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc4_d", pc4_d, 32'h0);

        // Asynchronous reset in the middle of a cycle.
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("t1_req", bus.req, 0);
        chk("t1_pc_d", pc_d, 0);
        chk("t1_pc4_d", pc4_d, 0);
        chk("t1_instr", instr, NOP);
        chk("t1_vld", instr_vld_d, 0);
        model_reset();
        bus.rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pre();
        chk("t1_req_release", bus.req, 1);
        chk("t1_addr_release", bus.addr, 32'h0);
        post();

        // Random traffic; a lone flush only when nothing is buffered.
        ready_mode = 0; rv_mode = 0;
        repeat (3000) begin
            stall_f   = ($urandom_range(0, 3) == 0);
            pc_sel    = ($urandom_range(0, 9) == 0);
            pc_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            flush_d   = pc_sel ? ($urandom_range(0, 1) == 1)
                               : ((fb_q.size() == 0) && ($urandom_range(0, 7) == 0));
            cyc();
        end
        stall_f = 1'b0; pc_sel = 1'b0; flush_d = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
